// File: rtl/store_drain_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : store_drain_pkg / store_drain_buffer_if
// Description : Load/store width encoding and the bundled commit, memory and
//               load-check signals of the store drain buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package store_drain_pkg;
  typedef enum logic [2:0] {
    LDST_BYTE   = 3'd0,
    LDST_HALF   = 3'd1,
    LDST_WORD   = 3'd2,
    LDST_BYTE_U = 3'd3,
    LDST_HALF_U = 3'd4
  } ldst_mode_t;
endpackage

interface store_drain_buffer_if;
  import store_drain_pkg::*;

  logic        store_enable;
  ldst_mode_t  store_mode;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        store_ready;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        ld_check_valid;
  logic [31:0] ld_check_addr;
  ldst_mode_t  ld_check_mode;
  logic        ld_conflict;

  logic        misalign_err;
  logic        empty;

  // Commit stage, memory and load unit side
  modport master (
    output store_enable, store_mode, store_addr, store_data,
    input  store_ready,
    input  mem_req_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_req_ready,
    output ld_check_valid, ld_check_addr, ld_check_mode,
    input  ld_conflict, misalign_err, empty
  );

  // Buffer side
  modport slave (
    input  store_enable, store_mode, store_addr, store_data,
    output store_ready,
    output mem_req_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_req_ready,
    input  ld_check_valid, ld_check_addr, ld_check_mode,
    output ld_conflict, misalign_err, empty
  );
endinterface
`default_nettype wire

// File: rtl/store_drain_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_drain_buffer
// Description : Queues committed stores as word-aligned writes with byte
//               strobes, drains them in order to data memory and flags
//               queued stores that overlap an issuing load.
// Revision    : 1.0 - initial release
// ============================================================================
module store_drain_buffer
  import store_drain_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire                  clk,
  input  wire                  rst_n,
  store_drain_buffer_if.slave  bus
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_DEPTH = (PTR_W + 1)'(DEPTH);

  // Byte lanes touched by an access of the given width at the given offset
  function automatic logic [3:0] lane_strb(input ldst_mode_t m, input logic [1:0] a);
    case (m)
      LDST_WORD:              lane_strb = 4'b1111;
      LDST_HALF, LDST_HALF_U: lane_strb = a[1] ? 4'b1100 : 4'b0011;
      default:                lane_strb = 4'b0001 << a;
    endcase
  endfunction

  // Store value replicated across every lane of its width
  function automatic logic [31:0] lane_data(input ldst_mode_t m, input logic [31:0] d);
    case (m)
      LDST_WORD:              lane_data = d;
      LDST_HALF, LDST_HALF_U: lane_data = {2{d[15:0]}};
      default:                lane_data = {4{d[7:0]}};
    endcase
  endfunction

  function automatic logic is_aligned(input ldst_mode_t m, input logic [1:0] a);
    case (m)
      LDST_WORD:              is_aligned = (a == 2'b00);
      LDST_HALF, LDST_HALF_U: is_aligned = ~a[0];
      default:                is_aligned = 1'b1;
    endcase
  endfunction

  logic [29:0]      r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [3:0]       r_strb [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_misalign;

  logic             w_ready;
  logic             w_valid;
  logic             w_aligned;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_ld_strb;
  logic [DEPTH-1:0] w_hit;

  // A full queue refuses stores outright, even if the head drains this cycle
  assign w_ready   = (r_count != c_DEPTH);
  assign w_valid   = (r_count != '0);
  assign w_aligned = is_aligned(bus.store_mode, bus.store_addr[1:0]);
  assign w_push    = bus.store_enable & w_ready & w_aligned;
  assign w_pop     = w_valid & bus.mem_req_ready;

  // Entry payload is formatted once at enqueue; storage needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= bus.store_addr[31:2];
      r_data[r_wr_ptr] <= lane_data(bus.store_mode, bus.store_data);
      r_strb[r_wr_ptr] <= lane_strb(bus.store_mode, bus.store_addr[1:0]);
    end
  end

  // Queue pointers, occupancy and the misalignment pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= bus.store_enable & w_ready & ~w_aligned;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_ld_strb = lane_strb(bus.ld_check_mode, bus.ld_check_addr[1:0]);

  // An entry is live when its distance from the head is below the occupancy
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_conflict
    logic [PTR_W-1:0] w_off;
    assign w_off     = PTR_W'(gi) - r_rd_ptr;
    assign w_hit[gi] = ({1'b0, w_off} < r_count)
                     & (r_addr[gi] == bus.ld_check_addr[31:2])
                     & (|(r_strb[gi] & w_ld_strb));
  end

  // Head outputs are zeroed while empty so stale entries never leak out
  assign bus.mem_req_valid = w_valid;
  assign bus.mem_addr      = w_valid ? {r_addr[r_rd_ptr], 2'b00} : 32'h0;
  assign bus.mem_wdata     = w_valid ? r_data[r_rd_ptr] : 32'h0;
  assign bus.mem_wstrb     = w_valid ? r_strb[r_rd_ptr] : 4'h0;
  assign bus.store_ready   = w_ready;
  assign bus.empty         = ~w_valid;
  assign bus.misalign_err  = r_misalign;
  assign bus.ld_conflict   = bus.ld_check_valid & (|w_hit);

endmodule
`default_nettype wire

// File: tb/tb_store_drain_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_drain_buffer
// Description : Self-checking bench for store_drain_buffer: lane-format
//               vector table, directed corner sequences and a randomized
//               run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_drain_buffer;
  import store_drain_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  store_drain_buffer_if bus ();

  store_drain_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  typedef struct {
    ldst_mode_t  mode;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  ent_t q[$];
  bit   m_mis;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int ref_size(input ldst_mode_t m);
    if (m == LDST_WORD) return 4;
    if (m == LDST_HALF || m == LDST_HALF_U) return 2;
    return 1;
  endfunction

  function automatic logic [3:0] ref_strb(input ldst_mode_t m, input logic [31:0] a);
    int sz = ref_size(m);
    if (sz == 4) return 4'hF;
    if (sz == 2) return 4'(3 << (a & 2));
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] ref_data(input ldst_mode_t m, input logic [31:0] d);
    int sz = ref_size(m);
    if (sz == 4) return d;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return (d & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic bit ref_conflict();
    logic [3:0] ls;
    if (!bus.ld_check_valid) return 1'b0;
    ls = ref_strb(bus.ld_check_mode, bus.ld_check_addr);
    foreach (q[i])
      if ((q[i].addr >> 2) == (bus.ld_check_addr >> 2) && (q[i].strb & ls) != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all();
    chk("store_ready", 32'(bus.store_ready), 32'(q.size() != DEPTH));
    chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(q.size() != 0));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("mem_addr", bus.mem_addr, q.size() != 0 ? q[0].addr : 32'h0);
    chk("mem_wdata", bus.mem_wdata, q.size() != 0 ? q[0].data : 32'h0);
    chk("mem_wstrb", 32'(bus.mem_wstrb), q.size() != 0 ? 32'(q[0].strb) : 32'h0);
    chk("ld_conflict", 32'(bus.ld_conflict), 32'(ref_conflict()));
    chk("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
  endtask

  // Check current outputs, predict the edge, clock, then update the model
  task automatic step();
    bit   push, pop, al, nmis;
    ent_t e;
    #1;
    check_all();
    al   = (bus.store_addr % ref_size(bus.store_mode)) == 0;
    pop  = (q.size() != 0) && bus.mem_req_ready;
    push = bus.store_enable && (q.size() != DEPTH) && al;
    nmis = bus.store_enable && (q.size() != DEPTH) && !al;
    e.addr = bus.store_addr & 32'hFFFF_FFFC;
    e.data = ref_data(bus.store_mode, bus.store_data);
    e.strb = ref_strb(bus.store_mode, bus.store_addr);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(e);
    m_mis = nmis;
    #1;
  endtask

  task automatic set_store(input bit en, input ldst_mode_t m, input logic [31:0] a, input logic [31:0] d);
    bus.store_enable = en;
    bus.store_mode   = m;
    bus.store_addr   = a;
    bus.store_data   = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_store(1'b0, LDST_WORD, 32'h0, 32'h0);
    bus.mem_req_ready  = 1'b0;
    bus.ld_check_valid = 1'b0;
    bus.ld_check_addr  = 32'h0;
    bus.ld_check_mode  = LDST_BYTE;
    #1;
    q.delete();
    m_mis = 1'b0;
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{LDST_BYTE,   32'h203, 32'h0000_00A5, 1'b0, 4'h8, 32'hA5A5_A5A5};
    vt[1] = '{LDST_HALF,   32'h202, 32'h0000_1234, 1'b0, 4'hC, 32'h1234_1234};
    vt[2] = '{LDST_WORD,   32'h100, 32'hDEAD_BEEF, 1'b0, 4'hF, 32'hDEAD_BEEF};
    vt[3] = '{LDST_BYTE_U, 32'h200, 32'h1234_5677, 1'b0, 4'h1, 32'h7777_7777};
    vt[4] = '{LDST_HALF_U, 32'h200, 32'h5555_ABCD, 1'b0, 4'h3, 32'hABCD_ABCD};
    vt[5] = '{LDST_BYTE,   32'h3FE, 32'h0000_FF11, 1'b0, 4'h4, 32'h1111_1111};
    vt[6] = '{LDST_WORD,   32'h102, 32'h1111_2222, 1'b1, 4'h0, 32'h0};
    vt[7] = '{LDST_HALF,   32'h201, 32'h3333_4444, 1'b1, 4'h0, 32'h0};
    vt[8] = '{LDST_WORD,   32'h101, 32'h5555_6666, 1'b1, 4'h0, 32'h0};

    do_reset();

    // Test 1: single WORD store, one-cycle latency, then drained
    set_store(1'b1, LDST_WORD, 32'h100, 32'hDEAD_BEEF);
    step();
    set_store(1'b0, LDST_WORD, 32'h0, 32'h0);
    chk("t1_valid", 32'(bus.mem_req_valid), 32'd1);
    chk("t1_addr", bus.mem_addr, 32'h100);
    chk("t1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("t1_wstrb", 32'(bus.mem_wstrb), 32'hF);
    bus.mem_req_ready = 1'b1;
    step();
    chk("t1_empty", 32'(bus.empty), 32'd1);
    bus.mem_req_ready = 1'b0;

    // Lane formatting / alignment table
    foreach (vt[i]) begin
      set_store(1'b1, vt[i].mode, vt[i].addr, vt[i].data);
      step();
      set_store(1'b0, LDST_WORD, 32'h0, 32'h0);
      if (vt[i].exp_mis) begin
        chk($sformatf("tbl%0d_mis", i), 32'(bus.misalign_err), 32'd1);
        chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'd1);
        step();
        chk($sformatf("tbl%0d_mis_end", i), 32'(bus.misalign_err), 32'd0);
      end else begin
        chk($sformatf("tbl%0d_strb", i), 32'(bus.mem_wstrb), 32'(vt[i].exp_strb));
        chk($sformatf("tbl%0d_wdata", i), bus.mem_wdata, vt[i].exp_wdata);
        chk($sformatf("tbl%0d_addr", i), bus.mem_addr, {vt[i].addr[31:2], 2'b00});
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready = 1'b0;
      end
    end

    // Test 2: BYTE then HALF drain in order
    set_store(1'b1, LDST_BYTE, 32'h203, 32'hA5);
    step();
    set_store(1'b1, LDST_HALF, 32'h202, 32'h1234);
    step();
    set_store(1'b0, LDST_WORD, 32'h0, 32'h0);
    chk("t2_first_strb", 32'(bus.mem_wstrb), 32'h8);
    chk("t2_first_data", bus.mem_wdata, 32'hA5A5_A5A5);
    bus.mem_req_ready = 1'b1;
    step();
    chk("t2_second_strb", 32'(bus.mem_wstrb), 32'hC);
    chk("t2_second_data", bus.mem_wdata, 32'h1234_1234);
    step();
    bus.mem_req_ready = 1'b0;

    // Test 3: fill, ignored fifth store, one pop reopens
    for (int i = 0; i < DEPTH; i++) begin
      set_store(1'b1, LDST_WORD, 32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
      step();
    end
    chk("t3_full_ready", 32'(bus.store_ready), 32'd0);
    set_store(1'b1, LDST_WORD, 32'h500, 32'hBAD0_BAD0);
    step();
    set_store(1'b0, LDST_WORD, 32'h0, 32'h0);
    chk("t3_still_full", 32'(bus.store_ready), 32'd0);
    chk("t3_head_stable", bus.mem_addr, 32'h400);
    bus.mem_req_ready = 1'b1;
    step();
    bus.mem_req_ready = 1'b0;
    chk("t3_ready_after_pop", 32'(bus.store_ready), 32'd1);
    bus.mem_req_ready = 1'b1;
    repeat (3) step();
    chk("t3_drained", 32'(bus.empty), 32'd1);
    bus.mem_req_ready = 1'b0;

    // Test 4: misaligned WORD with one entry queued
    set_store(1'b1, LDST_WORD, 32'h600, 32'h1);
    step();
    set_store(1'b1, LDST_WORD, 32'h102, 32'h2);
    step();
    set_store(1'b0, LDST_WORD, 32'h0, 32'h0);
    chk("t4_mis_pulse", 32'(bus.misalign_err), 32'd1);
    step();
    chk("t4_mis_one_cycle", 32'(bus.misalign_err), 32'd0);
    chk("t4_count_same", 32'(bus.store_ready && bus.mem_req_valid), 32'd1);
    bus.mem_req_ready = 1'b1;
    step();
    chk("t4_one_entry_only", 32'(bus.empty), 32'd1);
    bus.mem_req_ready = 1'b0;

    // Test 5: load overlap detection
    set_store(1'b1, LDST_BYTE, 32'h301, 32'h5A);
    step();
    set_store(1'b0, LDST_WORD, 32'h0, 32'h0);
    bus.ld_check_valid = 1'b1;
    bus.ld_check_addr = 32'h301; bus.ld_check_mode = LDST_BYTE; #1;
    chk("t5_byte_same", 32'(bus.ld_conflict), 32'd1);
    bus.ld_check_addr = 32'h302; #1;
    chk("t5_byte_other", 32'(bus.ld_conflict), 32'd0);
    bus.ld_check_addr = 32'h300; bus.ld_check_mode = LDST_WORD; #1;
    chk("t5_word", 32'(bus.ld_conflict), 32'd1);
    bus.ld_check_addr = 32'h304; #1;
    chk("t5_other_word", 32'(bus.ld_conflict), 32'd0);
    bus.ld_check_addr = 32'h300; bus.ld_check_valid = 1'b0; #1;
    chk("t5_not_valid", 32'(bus.ld_conflict), 32'd0);
    bus.ld_check_valid = 1'b1;
    bus.mem_req_ready = 1'b1; #1;
    chk("t5_popping_counts", 32'(bus.ld_conflict), 32'd1);
    step();
    bus.ld_check_valid = 1'b0;
    bus.mem_req_ready = 1'b0;

    // Test 6: asynchronous reset with three entries pending
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, LDST_WORD, 32'h700 + 32'(4 * i), 32'(i));
      step();
    end
    set_store(1'b0, LDST_WORD, 32'h0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", 32'(bus.mem_req_valid), 32'd0);
    chk("t6_empty", 32'(bus.empty), 32'd1);
    q.delete();
    m_mis = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready = 1'b1;
    repeat (3) step();
    chk("t6_no_replay", 32'(bus.mem_req_valid), 32'd0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      set_store($urandom_range(0, 99) < 60, ldst_mode_t'($urandom_range(0, 4)),
                32'h300 + 32'($urandom_range(0, 15)), $urandom);
      bus.mem_req_ready  = $urandom_range(0, 99) < 45;
      bus.ld_check_valid = $urandom_range(0, 1) == 1;
      bus.ld_check_mode  = ldst_mode_t'($urandom_range(0, 4));
      bus.ld_check_addr  = 32'h300 + 32'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
